// File: rtl/rv32_pkg.sv
// Shared RV32 register-file constants and the writeback entry type.
package rv32_pkg;

   localparam int XLEN      = 32;
   localparam int RF_ADDR_W = 5;
   localparam int NUM_REGS  = 32;

   typedef struct packed {
      logic [RF_ADDR_W-1:0] addr;
      logic [XLEN-1:0]      data;
   } wb_entry_t;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Producer-side bundle (WB stage, MD unit) and register-file write outputs of the arbiter.
interface reg_write_arbiter_if;
   import rv32_pkg::*;

   logic                 WB_VALID;
   logic [RF_ADDR_W-1:0] WB_ADDR;
   logic [XLEN-1:0]      WB_DATA;
   logic                 WB_STALL;

   logic                 MD_ISSUE;
   logic [RF_ADDR_W-1:0] MD_ISSUE_ADDR;
   logic                 MD_VALID;
   logic [RF_ADDR_W-1:0] MD_ADDR;
   logic [XLEN-1:0]      MD_DATA;
   logic                 MD_READY;

   logic [XLEN-1:0]      RF_IN;
   logic [RF_ADDR_W-1:0] RF_INADDRESS;
   logic                 RF_WRITE;
   logic [NUM_REGS-1:0]  BUSY_MASK;

   modport master (
      output WB_VALID, WB_ADDR, WB_DATA, MD_ISSUE, MD_ISSUE_ADDR, MD_VALID, MD_ADDR, MD_DATA,
      input  WB_STALL, MD_READY, RF_IN, RF_INADDRESS, RF_WRITE, BUSY_MASK
   );

   modport slave (
      input  WB_VALID, WB_ADDR, WB_DATA, MD_ISSUE, MD_ISSUE_ADDR, MD_VALID, MD_ADDR, MD_DATA,
      output WB_STALL, MD_READY, RF_IN, RF_INADDRESS, RF_WRITE, BUSY_MASK
   );

endinterface

// File: rtl/wb_result_fifo.sv
// Small power-of-two FIFO of writeback entries; head is visible combinationally.
// Pushes while full and pops while empty are ignored.
module wb_result_fifo
   import rv32_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  wb_entry_t push_dat,
   input  logic      pop,
   output logic      full,
   output logic      empty,
   output wb_entry_t head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   wb_entry_t       mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic            do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read once count says they are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat;
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the register-file write port between the WB stage and a FIFO of MD results,
// with a starvation guard that stalls WB and a busy scoreboard of outstanding MD destinations.
module reg_write_arbiter
   import rv32_pkg::*;
#(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input logic                CLK,
   input logic                RESET,
   reg_write_arbiter_if.slave bus
);

   localparam int             SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);

   wb_entry_t           push_dat, fifo_head;
   logic                fifo_full, fifo_empty;
   logic                md_ready, md_push, fifo_pop;
   logic                wb_req, force_md, grant_fifo, grant_wb;
   logic [SW-1:0]       starve_q, starve_d;
   logic [NUM_REGS-1:0] busy_q, busy_d;

   assign push_dat   = '{addr: bus.MD_ADDR, data: bus.MD_DATA};
   assign md_ready   = !RESET && !fifo_full;
   assign md_push    = bus.MD_VALID && md_ready;

   assign wb_req     = bus.WB_VALID && (bus.WB_ADDR != '0);
   assign force_md   = !fifo_empty && (starve_q == STARVE_MAX);
   assign grant_fifo = !fifo_empty && (force_md || !wb_req);
   assign grant_wb   = wb_req && !force_md;
   assign fifo_pop   = grant_fifo && !RESET;

   wb_result_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (CLK),
      .rst      (RESET),
      .push     (md_push),
      .push_dat (push_dat),
      .pop      (fifo_pop),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .head     (fifo_head)
   );

   always_comb begin
      bus.RF_WRITE     = 1'b0;
      bus.RF_INADDRESS = '0;
      bus.RF_IN        = '0;
      bus.WB_STALL     = 1'b0;
      bus.MD_READY     = md_ready;
      bus.BUSY_MASK    = RESET ? '0 : busy_q;
      if (!RESET) begin
         bus.WB_STALL = force_md && wb_req;
         if (grant_wb) begin
            bus.RF_WRITE     = 1'b1;
            bus.RF_INADDRESS = bus.WB_ADDR;
            bus.RF_IN        = bus.WB_DATA;
         end else if (grant_fifo) begin
            // x0 entries still drain from the FIFO, they just never write.
            bus.RF_WRITE     = (fifo_head.addr != '0);
            bus.RF_INADDRESS = fifo_head.addr;
            bus.RF_IN        = fifo_head.data;
         end
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (fifo_empty || grant_fifo) begin
         starve_d = '0;
      end else if (starve_q != STARVE_MAX) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // Clear before set so a same-cycle re-issue of the popped register keeps its bit.
   always_comb begin
      busy_d = busy_q;
      if (fifo_pop) busy_d[fifo_head.addr] = 1'b0;
      if (bus.MD_ISSUE && (bus.MD_ISSUE_ADDR != '0)) busy_d[bus.MD_ISSUE_ADDR] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         starve_q <= '0;
         busy_q   <= '0;
      end else begin
         starve_q <= starve_d;
         busy_q   <= busy_d;
      end
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with default parameters (FIFO_DEPTH=2, STARVE_LIMIT=4).
module tb_reg_write_arbiter;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   reg_write_arbiter_if bus ();

   reg_write_arbiter #(
      .FIFO_DEPTH   (2),
      .STARVE_LIMIT (4)
   ) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst               = 1'b1;
      bus.WB_VALID      = 1'b1;
      bus.WB_ADDR       = 5'd3;
      bus.WB_DATA       = 32'h33;
      bus.MD_ISSUE      = 1'b1;
      bus.MD_ISSUE_ADDR = 5'd7;
      bus.MD_VALID      = 1'b1;
      bus.MD_ADDR       = 5'd4;
      bus.MD_DATA       = 32'h44;

      // Reset held two cycles with producers active
      settle();
      chk("rst_rf_write", 32'(bus.RF_WRITE), 32'd0);
      chk("rst_rf_in", bus.RF_IN, 32'd0);
      chk("rst_rf_addr", 32'(bus.RF_INADDRESS), 32'd0);
      chk("rst_wb_stall", 32'(bus.WB_STALL), 32'd0);
      chk("rst_md_ready", 32'(bus.MD_READY), 32'd0);
      chk("rst_busy", bus.BUSY_MASK, 32'd0);
      tick();
      chk("rst2_md_ready", 32'(bus.MD_READY), 32'd0);
      tick();
      rst          = 1'b0;
      bus.WB_VALID = 1'b0;
      bus.MD_ISSUE = 1'b0;
      bus.MD_VALID = 1'b0;
      settle();
      chk("post_rst_md_ready", 32'(bus.MD_READY), 32'd1);
      chk("post_rst_busy", bus.BUSY_MASK, 32'd0);
      chk("post_rst_rf_write", 32'(bus.RF_WRITE), 32'd0);

      // MD path: issue x5, result accepted, written next cycle, busy cleared at that edge
      bus.MD_ISSUE      = 1'b1;
      bus.MD_ISSUE_ADDR = 5'd5;
      tick();
      bus.MD_ISSUE = 1'b0;
      chk("md_busy_set", bus.BUSY_MASK, 32'h0000_0020);
      bus.MD_VALID = 1'b1;
      bus.MD_ADDR  = 5'd5;
      bus.MD_DATA  = 32'hDEAD_BEEF;
      settle();
      chk("md_ready", 32'(bus.MD_READY), 32'd1);
      chk("md_no_bypass", 32'(bus.RF_WRITE), 32'd0);
      tick();
      bus.MD_VALID = 1'b0;
      settle();
      chk("md_rf_write", 32'(bus.RF_WRITE), 32'd1);
      chk("md_rf_addr", 32'(bus.RF_INADDRESS), 32'd5);
      chk("md_rf_in", bus.RF_IN, 32'hDEAD_BEEF);
      chk("md_busy_held", bus.BUSY_MASK, 32'h0000_0020);
      tick();
      chk("md_busy_clr", bus.BUSY_MASK, 32'd0);
      chk("md_idle", 32'(bus.RF_WRITE), 32'd0);

      // Starvation: WB to x1..x7 every cycle, one MD result to x20 queued
      bus.MD_ISSUE      = 1'b1;
      bus.MD_ISSUE_ADDR = 5'd20;
      tick();
      bus.MD_ISSUE = 1'b0;
      bus.WB_VALID = 1'b1;
      bus.WB_ADDR  = 5'd1;
      bus.WB_DATA  = 32'h101;
      bus.MD_VALID = 1'b1;
      bus.MD_ADDR  = 5'd20;
      bus.MD_DATA  = 32'hAAAA;
      settle();
      chk("stv_wb1", 32'(bus.RF_INADDRESS), 32'd1);
      tick();
      bus.MD_VALID = 1'b0;
      for (int k = 2; k <= 5; k++) begin
         bus.WB_ADDR = 5'(k);
         bus.WB_DATA = 32'h100 + 32'(k);
         settle();
         chk("stv_wb_addr", 32'(bus.RF_INADDRESS), 32'(k));
         chk("stv_wb_stall", 32'(bus.WB_STALL), 32'd0);
         tick();
      end
      bus.WB_ADDR = 5'd6;
      bus.WB_DATA = 32'h106;
      settle();
      chk("stv_force_stall", 32'(bus.WB_STALL), 32'd1);
      chk("stv_force_write", 32'(bus.RF_WRITE), 32'd1);
      chk("stv_force_addr", 32'(bus.RF_INADDRESS), 32'd20);
      chk("stv_force_data", bus.RF_IN, 32'hAAAA);
      tick();
      chk("stv_held_stall", 32'(bus.WB_STALL), 32'd0);
      chk("stv_held_addr", 32'(bus.RF_INADDRESS), 32'd6);
      chk("stv_held_data", bus.RF_IN, 32'h106);
      chk("stv_busy_clr", bus.BUSY_MASK, 32'd0);
      tick();
      bus.WB_ADDR = 5'd7;
      bus.WB_DATA = 32'h107;
      settle();
      chk("stv_wb7", 32'(bus.RF_INADDRESS), 32'd7);
      tick();
      bus.WB_VALID = 1'b0;

      // Full FIFO: WB busy on x1, MD results to x10, x11, x12
      for (int r = 10; r <= 12; r++) begin
         bus.MD_ISSUE      = 1'b1;
         bus.MD_ISSUE_ADDR = 5'(r);
         tick();
      end
      bus.MD_ISSUE = 1'b0;
      chk("full_busy", bus.BUSY_MASK, 32'h0000_1C00);
      bus.WB_VALID = 1'b1;
      bus.WB_ADDR  = 5'd1;
      bus.WB_DATA  = 32'h111;
      bus.MD_VALID = 1'b1;
      bus.MD_ADDR  = 5'd10;
      bus.MD_DATA  = 32'h10;
      tick();
      bus.MD_ADDR = 5'd11;
      bus.MD_DATA = 32'h11;
      settle();
      chk("full_rdy_1", 32'(bus.MD_READY), 32'd1);
      tick();
      bus.MD_ADDR = 5'd12;
      bus.MD_DATA = 32'h12;
      settle();
      chk("full_rdy_0a", 32'(bus.MD_READY), 32'd0);
      tick();
      chk("full_rdy_0b", 32'(bus.MD_READY), 32'd0);
      tick();
      chk("full_rdy_0c", 32'(bus.MD_READY), 32'd0);
      tick();
      chk("full_force_stall", 32'(bus.WB_STALL), 32'd1);
      chk("full_force_addr", 32'(bus.RF_INADDRESS), 32'd10);
      chk("full_force_data", bus.RF_IN, 32'h10);
      chk("full_rdy_0d", 32'(bus.MD_READY), 32'd0);
      tick();
      chk("full_rdy_after_pop", 32'(bus.MD_READY), 32'd1);
      chk("full_wb_resume", 32'(bus.RF_INADDRESS), 32'd1);
      tick();
      bus.MD_VALID = 1'b0;
      bus.WB_VALID = 1'b0;
      settle();
      chk("full_drain11_addr", 32'(bus.RF_INADDRESS), 32'd11);
      chk("full_drain11_data", bus.RF_IN, 32'h11);
      tick();
      chk("full_drain12_addr", 32'(bus.RF_INADDRESS), 32'd12);
      chk("full_drain12_data", bus.RF_IN, 32'h12);
      tick();
      chk("full_empty_write", 32'(bus.RF_WRITE), 32'd0);
      chk("full_busy_clr", bus.BUSY_MASK, 32'd0);

      // x0 handling: x0 MD result drains silently, then x13 follows directly behind it
      bus.MD_ISSUE      = 1'b1;
      bus.MD_ISSUE_ADDR = 5'd13;
      tick();
      bus.MD_ISSUE = 1'b0;
      bus.MD_VALID = 1'b1;
      bus.MD_ADDR  = 5'd0;
      bus.MD_DATA  = 32'h55;
      tick();
      bus.MD_ADDR = 5'd13;
      bus.MD_DATA = 32'h1313;
      settle();
      chk("x0_md_no_write", 32'(bus.RF_WRITE), 32'd0);
      tick();
      bus.MD_VALID = 1'b0;
      settle();
      chk("x0_next_write", 32'(bus.RF_WRITE), 32'd1);
      chk("x0_next_addr", 32'(bus.RF_INADDRESS), 32'd13);
      tick();
      bus.WB_VALID = 1'b1;
      bus.WB_ADDR  = 5'd0;
      bus.WB_DATA  = 32'h77;
      settle();
      chk("x0_wb_write", 32'(bus.RF_WRITE), 32'd0);
      chk("x0_wb_stall", 32'(bus.WB_STALL), 32'd0);
      bus.WB_VALID      = 1'b0;
      bus.MD_ISSUE      = 1'b1;
      bus.MD_ISSUE_ADDR = 5'd0;
      tick();
      bus.MD_ISSUE = 1'b0;
      chk("x0_issue_busy", bus.BUSY_MASK, 32'd0);

      // Set-wins: x9 popped while x9 is re-issued
      bus.MD_ISSUE      = 1'b1;
      bus.MD_ISSUE_ADDR = 5'd9;
      tick();
      bus.MD_ISSUE = 1'b0;
      bus.MD_VALID = 1'b1;
      bus.MD_ADDR  = 5'd9;
      bus.MD_DATA  = 32'h99;
      tick();
      bus.MD_VALID      = 1'b0;
      bus.MD_ISSUE      = 1'b1;
      bus.MD_ISSUE_ADDR = 5'd9;
      settle();
      chk("sw_pop_addr", 32'(bus.RF_INADDRESS), 32'd9);
      tick();
      bus.MD_ISSUE = 1'b0;
      chk("sw_busy_kept", bus.BUSY_MASK, 32'h0000_0200);
      tick();
      chk("sw_busy_stable", bus.BUSY_MASK, 32'h0000_0200);

      // Reset clears the scoreboard
      rst = 1'b1;
      settle();
      chk("rst_busy_gated", bus.BUSY_MASK, 32'd0);
      tick();
      rst = 1'b0;
      settle();
      chk("rst_busy_cleared", bus.BUSY_MASK, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
